// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-consumer bundle for the UART receive byte FIFO.
// The master drives receiver and consumer strobes; the slave is the FIFO itself.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    rx_data;
  logic          rx_data_ready;
  logic          flush;
  logic          out_ready;
  logic          overflow_clr;
  logic [7:0]    out_data;
  logic          out_valid;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          overflow;

  modport master (
    output rx_data, rx_data_ready, flush, out_ready, overflow_clr,
    input  out_data, out_valid, count, almost_full, overflow
  );

  modport slave (
    input  rx_data, rx_data_ready, flush, out_ready, overflow_clr,
    output out_data, out_valid, count, almost_full, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// FWFT byte FIFO behind the UART receiver: one push per data_ready rising edge, 1-cycle latency.
// Consumer backpressure via out_ready; bytes arriving while full (and not popping) are dropped and flagged.
module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic           clk,
  input  logic           nRst,
  uart_rx_fifo_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rdy_q;
  logic          overflow_q, overflow_d;

  logic push_req;
  logic pop;
  logic push;
  logic drop;
  logic full;
  logic not_empty;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign push_req  = bus.rx_data_ready & ~rdy_q;
  assign pop       = not_empty & bus.out_ready;
  // Popping a full FIFO frees the slot the incoming byte needs.
  assign push      = push_req & (~full | pop);
  // A byte lost to flush is intentional, not an overflow.
  assign drop      = push_req & full & ~pop & ~bus.flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end

    if (drop)                  overflow_d = 1'b1;
    else if (bus.overflow_clr) overflow_d = 1'b0;
  end

  // rdy_q resets high so a data_ready already asserted at reset release is ignored.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rdy_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rdy_q      <= bus.rx_data_ready;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (nRst && push && !bus.flush) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.out_data    = not_empty ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.out_valid   = not_empty;
  assign bus.count       = count_q;
  assign bus.almost_full = (count_q >= AFULL_CNT);
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: hand-computed expectations for reset, fill/drain, wrap,
// overflow, full push+pop, flush race and stale data_ready across reset.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic clk;
  logic nRst;
  int   tests_run;
  int   tests_failed;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.rx_data       = b;
    bus.rx_data_ready = 1'b1;
    tick();
    bus.rx_data_ready = 1'b0;
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    nRst              = 1'b0;
    bus.rx_data       = 8'h00;
    bus.rx_data_ready = 1'b0;
    bus.flush         = 1'b0;
    bus.out_ready     = 1'b0;
    bus.overflow_clr  = 1'b0;

    // 1. reset values and a single byte with a long data_ready level
    tick();
    tick();
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_data", 32'(bus.out_data), 32'h00);
    check_eq("rst_count", 32'(bus.count), 32'd0);
    check_eq("rst_afull", 32'(bus.almost_full), 32'd0);
    check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
    nRst = 1'b1;
    tick();
    bus.rx_data       = 8'hA5;
    bus.rx_data_ready = 1'b1;
    tick();
    check_eq("one_count", 32'(bus.count), 32'd1);
    check_eq("one_data", 32'(bus.out_data), 32'hA5);
    check_eq("one_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check_eq("one_level_count", 32'(bus.count), 32'd1);
    bus.rx_data_ready = 1'b0;
    bus.out_ready     = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq("one_pop_valid", 32'(bus.out_valid), 32'd0);
    check_eq("one_pop_data", 32'(bus.out_data), 32'h00);

    // 2. fill with almost_full threshold tracking
    for (int i = 0; i < DEPTH; i++) begin
      bus.rx_data       = 8'(i);
      bus.rx_data_ready = 1'b1;
      tick();
      check_eq($sformatf("fill_afull_%0d", i + 1), 32'(bus.almost_full),
               ((i + 1) >= AFULL) ? 32'd1 : 32'd0);
      bus.rx_data_ready = 1'b0;
      tick();
    end
    check_eq("full_count", 32'(bus.count), 32'd16);
    check_eq("full_head", 32'(bus.out_data), 32'h00);

    // 3. overflow: drop, clear racing a drop, clear alone
    push_byte(8'hEE);
    check_eq("drop_count", 32'(bus.count), 32'd16);
    check_eq("drop_ovf", 32'(bus.overflow), 32'd1);
    check_eq("drop_head", 32'(bus.out_data), 32'h00);
    bus.rx_data_ready = 1'b1;
    bus.overflow_clr  = 1'b1;
    tick();
    check_eq("clr_vs_drop_ovf", 32'(bus.overflow), 32'd1);
    bus.rx_data_ready = 1'b0;
    tick();
    check_eq("clr_alone_ovf", 32'(bus.overflow), 32'd0);
    bus.overflow_clr = 1'b0;

    // 4. full with simultaneous push and pop, then in-order drain
    bus.rx_data       = 8'h77;
    bus.rx_data_ready = 1'b1;
    bus.out_ready     = 1'b1;
    tick();
    bus.rx_data_ready = 1'b0;
    bus.out_ready     = 1'b0;
    check_eq("pp_full_count", 32'(bus.count), 32'd16);
    check_eq("pp_full_ovf", 32'(bus.overflow), 32'd0);
    check_eq("pp_full_head", 32'(bus.out_data), 32'h01);
    bus.out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      check_eq($sformatf("drain_%0d", k), 32'(bus.out_data), (k < 15) ? 32'(k + 1) : 32'h77);
      tick();
    end
    bus.out_ready = 1'b0;
    check_eq("drain_valid", 32'(bus.out_valid), 32'd0);
    check_eq("drain_data", 32'(bus.out_data), 32'h00);
    check_eq("drain_count", 32'(bus.count), 32'd0);

    // pointer wrap with three entries in flight
    push_byte(8'h40);
    push_byte(8'h41);
    push_byte(8'h42);
    for (int k = 0; k < 20; k++) begin
      check_eq($sformatf("wrap_head_%0d", k), 32'(bus.out_data), 32'(8'h40 + k));
      bus.rx_data       = 8'(8'h43 + k);
      bus.rx_data_ready = 1'b1;
      bus.out_ready     = 1'b1;
      tick();
      bus.rx_data_ready = 1'b0;
      bus.out_ready     = 1'b0;
      tick();
    end
    check_eq("wrap_count", 32'(bus.count), 32'd3);
    check_eq("wrap_head_final", 32'(bus.out_data), 32'h54);

    // 5. flush racing a push and a pop
    push_byte(8'h90);
    push_byte(8'h91);
    check_eq("pre_flush_count", 32'(bus.count), 32'd5);
    bus.rx_data       = 8'h33;
    bus.rx_data_ready = 1'b1;
    bus.out_ready     = 1'b1;
    bus.flush         = 1'b1;
    tick();
    bus.rx_data_ready = 1'b0;
    bus.out_ready     = 1'b0;
    bus.flush         = 1'b0;
    check_eq("flush_count", 32'(bus.count), 32'd0);
    check_eq("flush_valid", 32'(bus.out_valid), 32'd0);
    check_eq("flush_ovf", 32'(bus.overflow), 32'd0);
    tick();
    check_eq("flush_no33_valid", 32'(bus.out_valid), 32'd0);
    check_eq("flush_no33_data", 32'(bus.out_data), 32'h00);

    // 6. reset mid-stream with data_ready held high across it
    for (int i = 0; i < 6; i++) push_byte(8'(8'hB0 + i));
    bus.rx_data       = 8'hB6;
    bus.rx_data_ready = 1'b1;
    tick();
    check_eq("pre_rst_count", 32'(bus.count), 32'd7);
    nRst = 1'b0;
    tick();
    tick();
    nRst = 1'b1;
    tick();
    check_eq("post_rst_count", 32'(bus.count), 32'd0);
    check_eq("post_rst_valid", 32'(bus.out_valid), 32'd0);
    tick();
    tick();
    check_eq("stale_rdy_count", 32'(bus.count), 32'd0);
    bus.rx_data_ready = 1'b0;
    tick();
    bus.rx_data       = 8'hC3;
    bus.rx_data_ready = 1'b1;
    tick();
    bus.rx_data_ready = 1'b0;
    check_eq("rearm_count", 32'(bus.count), 32'd1);
    check_eq("rearm_data", 32'(bus.out_data), 32'hC3);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
